// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
// DATA_WIDTH_DEF must track the datapath width define.
package shift_add_mult_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_A = 3'd2,
    S_CALC   = 3'd3,
    S_OUT_LO = 3'd4,
    S_OUT_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;
endpackage

// File: rtl/shift_add_mult_ctrl_iter_cnt.sv
// Iteration counter: sync clear, count enable, terminal-count flag at LAST.
module mult_iter_cnt #(
  parameter int CNT_W = 4,
  parameter int LAST  = 7
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= cnt + 1'b1;
  end

  assign o_tc = (cnt == CNT_W'(LAST));
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the 8-bit shift-and-add multiplier datapath: operand load,
// DATA_WIDTH add/shift iterations, then two-byte product handshake.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_data_valid,
  output logic o_data_ready,
  input  logic A_out,
  output logic load_B,
  output logic load_A,
  output logic load_ACC,
  output logic clr_ACC_reg,
  output logic sel_SUM,
  output logic shift_A_reg,
  output logic Lsb_out,
  output logic Msb_out,
  output logic o_out_valid,
  input  logic i_out_ready,
  output logic o_busy,
  output logic o_done
);
  state_t state;
  logic   b_hs, a_hs, calc_en, cnt_tc;

  // Abort masks every datapath strobe so nothing is written in that cycle.
  assign b_hs    = (state == S_LOAD_B) && i_data_valid && !i_abort;
  assign a_hs    = (state == S_LOAD_A) && i_data_valid && !i_abort;
  assign calc_en = (state == S_CALC) && !i_abort;

  assign o_data_ready = (state == S_LOAD_B) || (state == S_LOAD_A);
  assign load_B       = b_hs;
  assign load_A       = a_hs;
  assign clr_ACC_reg  = a_hs;
  assign load_ACC     = calc_en;
  assign shift_A_reg  = calc_en;
  assign sel_SUM      = calc_en && A_out;
  assign Lsb_out      = (state == S_OUT_LO);
  assign Msb_out      = (state == S_OUT_HI);
  assign o_out_valid  = Lsb_out || Msb_out;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);

  mult_iter_cnt #(.CNT_W(CNT_W), .LAST(DATA_WIDTH - 1)) u_iter_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (a_hs || i_abort),
    .i_en    (calc_en),
    .o_tc    (cnt_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else if (i_abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (i_start)      state <= S_LOAD_B;
        S_LOAD_B: if (i_data_valid) state <= S_LOAD_A;
        S_LOAD_A: if (i_data_valid) state <= S_CALC;
        S_CALC:   if (cnt_tc)       state <= S_OUT_LO;
        S_OUT_LO: if (i_out_ready)  state <= S_OUT_HI;
        S_OUT_HI: if (i_out_ready)  state <= S_DONE;
        S_DONE:                     state <= S_IDLE;
        default:                    state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a behavioural shift-and-add datapath.
module tb_shift_add_mult_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, valid = 1'b0, out_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic o_data_ready, A_out, load_B, load_A, load_ACC, clr_ACC_reg, sel_SUM, shift_A_reg;
  logic Lsb_out, Msb_out, o_out_valid, o_busy, o_done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_data_valid(valid), .o_data_ready(o_data_ready), .A_out(A_out),
    .load_B(load_B), .load_A(load_A), .load_ACC(load_ACC), .clr_ACC_reg(clr_ACC_reg),
    .sel_SUM(sel_SUM), .shift_A_reg(shift_A_reg), .Lsb_out(Lsb_out), .Msb_out(Msb_out),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_busy(o_busy), .o_done(o_done)
  );

  // Datapath: B, A (multiplicand / low product), ACC, adder, sum mux.
  logic [7:0] db = 8'h00, da = 8'h00, dacc = 8'h00;
  logic [8:0] sum9;
  assign sum9  = {1'b0, dacc} + {1'b0, (sel_SUM ? db : 8'h00)};
  assign A_out = da[0];
  always @(posedge clk) begin
    if (load_B) db <= data_in;
    if (load_A) da <= data_in;
    if (clr_ACC_reg) dacc <= 8'h00;
    if (load_ACC && shift_A_reg) begin
      dacc <= sum9[8:1];
      da   <= {sum9[0], da[7:1]};
    end
  end

  wire [11:0] outs = {o_data_ready, load_B, load_A, load_ACC, clr_ACC_reg, sel_SUM,
                      shift_A_reg, Lsb_out, Msb_out, o_out_valid, o_busy, o_done};

  task automatic test_reset();
    #2;
    checks++;
    if (outs !== 12'h000) begin errors++; $display("FAIL reset_outs: got %h want 000", outs); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 12'h000) begin errors++; $display("FAIL post_reset_idle: got %h want 000", outs); end
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 of cycle 0; returns at posedge+1 of the cycle after o_done.
  task automatic do_mult(input string name, input logic [7:0] b, input logic [7:0] a,
                         input int b_stall, input int hi_stall,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi, input int exp_sel);
    int n = 0, tB = -1, tA = -1, tLo = -1, tHi = -1, tDone = -1;
    int nB = 0, nA = 0, nSh = 0, nSel = 0, nExcl = 0;
    logic [7:0] lo = 8'hxx, hi = 8'hxx;
    bit done_seen = 0, idle0 = 0;
    start = 1'b1; data_in = b; valid = (b_stall == 0); out_ready = 1'b1;
    while (!done_seen && n < 60) begin
      @(negedge clk);
      if (n == 0) idle0 = !o_busy;
      if ((load_A && load_B) || (Lsb_out && Msb_out) || (sel_SUM && !load_ACC)) nExcl++;
      if (load_B) begin nB++; tB = n; end
      if (load_A) begin nA++; tA = n; end
      if (load_ACC && shift_A_reg) nSh++;
      if (sel_SUM) nSel++;
      if (Lsb_out && o_out_valid && out_ready) begin lo = da; tLo = n; end
      if (Msb_out && o_out_valid && out_ready) begin hi = dacc; tHi = n; end
      if (o_done) begin tDone = n; done_seen = 1; end
      @(posedge clk); #1; n++;
      start = 1'b0;
      valid = (n > b_stall);
      if (nB > 0) data_in = a;
      out_ready = !(n >= 12 + b_stall && n < 12 + b_stall + hi_stall);
    end
    valid = 1'b0; out_ready = 1'b0;
    checks++; if (!done_seen) begin errors++; $display("FAIL %s timeout: no o_done in 60 cycles", name); end
    checks++; if (!idle0) begin errors++; $display("FAIL %s idle_at_start: busy at cycle 0", name); end
    checks++; if (nExcl != 0) begin errors++; $display("FAIL %s exclusion: %0d bad cycles want 0", name, nExcl); end
    checks++; if (tB != 1 + b_stall) begin errors++; $display("FAIL %s load_B_cycle: got %0d want %0d", name, tB, 1 + b_stall); end
    checks++; if (tA != 2 + b_stall) begin errors++; $display("FAIL %s load_A_cycle: got %0d want %0d", name, tA, 2 + b_stall); end
    checks++; if (nB != 1 || nA != 1) begin errors++; $display("FAIL %s load_count: B=%0d A=%0d want 1/1", name, nB, nA); end
    checks++; if (nSh != 8) begin errors++; $display("FAIL %s shift_count: got %0d want 8", name, nSh); end
    checks++; if (nSel != exp_sel) begin errors++; $display("FAIL %s sel_SUM_count: got %0d want %0d", name, nSel, exp_sel); end
    checks++; if (tLo != 11 + b_stall) begin errors++; $display("FAIL %s lo_cycle: got %0d want %0d", name, tLo, 11 + b_stall); end
    checks++; if (tHi != 12 + b_stall + hi_stall) begin errors++; $display("FAIL %s hi_cycle: got %0d want %0d", name, tHi, 12 + b_stall + hi_stall); end
    checks++; if (tDone != 13 + b_stall + hi_stall) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, tDone, 13 + b_stall + hi_stall); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s low_byte: got %h want %h", name, lo, exp_lo); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s high_byte: got %h want %h", name, hi, exp_hi); end
  endtask

  task automatic test_basic();
    do_mult("13x11", 8'd13, 8'd11, 0, 0, 8'h8F, 8'h00, 3);
  endtask

  task automatic test_back_to_back();
    do_mult("255x255", 8'd255, 8'd255, 0, 0, 8'h01, 8'hFE, 8);
  endtask

  task automatic test_zero();
    do_mult("0x200", 8'd0, 8'd200, 0, 0, 8'h00, 8'h00, 3);
    do_mult("200x0", 8'd200, 8'd0, 0, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic test_backpressure();
    do_mult("6x7_stall", 8'd6, 8'd7, 3, 4, 8'h2A, 8'h00, 3);
  endtask

  task automatic test_reset_mid_calc();
    int bad = 0;
    start = 1'b1; valid = 1'b1; data_in = 8'd13; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;                // cycle 1: LOAD_B
    @(posedge clk); #1; data_in = 8'd11;             // cycle 2: LOAD_A
    repeat (4) begin @(posedge clk); #1; end         // cycle 6: CALC iteration 4
    @(negedge clk);
    checks++;
    if (load_ACC !== 1'b1) begin errors++; $display("FAIL rst_mid_calc_pre: load_ACC=%b want 1", load_ACC); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 12'h000) begin errors++; $display("FAIL rst_mid_calc_outs: got %h want 000", outs); end
    @(posedge clk); #1; rst_n = 1'b1; valid = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (o_done || o_busy) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_calc_idle: %0d busy/done cycles want 0", bad); end
    do_mult("3x5_after_rst", 8'd3, 8'd5, 0, 0, 8'h0F, 8'h00, 2);
  endtask

  task automatic test_abort();
    int bad = 0;
    start = 1'b1; valid = 1'b1; data_in = 8'd7; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;                // cycle 1: LOAD_B
    @(posedge clk); #1; data_in = 8'd9; abort = 1'b1; // cycle 2: LOAD_A + abort
    @(negedge clk);
    checks++;
    if (o_data_ready !== 1'b1 || load_A !== 1'b0 || clr_ACC_reg !== 1'b0) begin
      errors++;
      $display("FAIL abort_suppress: ready=%b load_A=%b clr=%b want 1/0/0", o_data_ready, load_A, clr_ACC_reg);
    end
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b want 0", o_busy); end
    @(posedge clk); #1; valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_done || o_busy || load_A || load_B || load_ACC) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_no_done: %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
